// File: rtl/core_logic_pkg.sv
// core_logic_pkg: shared byte width, opcodes and port-state encoding for core_logic
package core_logic_pkg;
  localparam int BYTE_WIDTH = 8;
  localparam logic [7:0] MCU_STATE_OPCODE = 8'h00;
  localparam logic [7:0] MCU_STATE_ACCESS_RAM = 8'h01;
  typedef enum logic [1:0] {IDLE, OPCODE, RAM, DISCARD} port_state_t;
endpackage

// File: rtl/core_logic_spi_slave_port.sv
// core_logic_spi_slave_port: oversampled SPI slave front end, opcode deserializer and port FSM
module core_logic_spi_slave_port
  import core_logic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic nss,
  input  logic sck,
  input  logic mosi,
  input  logic grant,
  output logic req,
  output logic own,
  output logic own_next,
  output logic sck_fwd,
  output logic mosi_fwd
);
  localparam int CW = $clog2(BYTE_WIDTH);
  logic [SYNC_STAGES-1:0] nss_q, sck_q, mosi_q;
  logic nss_s, sck_s, mosi_s, nss_d, sck_d, armed;
  logic nss_fall, nss_rise, sck_rise, done;
  logic [CW-1:0] cnt;
  logic [BYTE_WIDTH-1:0] sr, byte_c;
  port_state_t state, state_n;
  assign nss_s = nss_q[SYNC_STAGES-1];
  assign sck_s = sck_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign nss_fall = ~nss_s & nss_d;
  assign nss_rise = nss_s & ~nss_d;
  assign sck_rise = sck_s & ~sck_d;
  assign byte_c = {mosi_s, sr[BYTE_WIDTH-1:1]};
  assign own = state == RAM;
  assign own_next = state_n == RAM;
  // the SCK high phase that completed the opcode must not leak to the RAM
  assign sck_fwd = own & armed & sck_s;
  assign mosi_fwd = own & mosi_s;
  always_comb begin
    done = state == OPCODE && sck_rise && cnt == CW'(BYTE_WIDTH - 1);
    req = done && !nss_rise && byte_c == BYTE_WIDTH'(MCU_STATE_ACCESS_RAM);
    state_n = nss_rise ? IDLE :
              (state == IDLE && nss_fall) ? OPCODE :
              !done ? state :
              byte_c == BYTE_WIDTH'(MCU_STATE_OPCODE) ? DISCARD :
              grant ? RAM : DISCARD;
  end
  // synchronizers clear to 0 so an NSS already low at reset release is not taken as a fall
  always_ff @(posedge clk) begin
    if (reset) begin
      nss_q <= '0;
      sck_q <= '0;
      mosi_q <= '0;
      nss_d <= 1'b0;
      sck_d <= 1'b0;
      armed <= 1'b0;
      cnt <= '0;
      sr <= '0;
      state <= IDLE;
    end else begin
      nss_q <= {nss_q[SYNC_STAGES-2:0], nss};
      sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      nss_d <= nss_s;
      sck_d <= sck_s;
      armed <= own & (armed | ~sck_s);
      cnt <= state == IDLE ? '0 : (state == OPCODE && sck_rise) ? cnt + 1'b1 : cnt;
      if (state == OPCODE && sck_rise) sr <= byte_c;
      state <= state_n;
    end
  end
endmodule

// File: rtl/core_logic.sv
// core_logic: MCU/coprocessor SPI glue with an arbitrated pass-through bridge to an SPI RAM.
// CORE_LOGIC_COP_EN adds the coprocessor port; without it the MCU always owns the bridge.
module core_logic
  import core_logic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mcu_nss,
  input  logic mcu_sck,
  input  logic mcu_mosi,
  output logic mcu_miso,
  input  logic cop_nss,
  input  logic cop_sck,
  input  logic cop_mosi,
  output logic cop_miso,
  output logic ram_nss,
  output logic ram_sck,
  output logic ram_mosi,
  input  logic ram_miso
);
  logic m_req, m_grant, m_own, m_own_n, m_sck, m_mosi;
  logic c_own, c_own_n, c_sck, c_mosi;
  core_logic_spi_slave_port #(.SYNC_STAGES(SYNC_STAGES)) u_mcu (
    .clk(clk), .reset(reset), .nss(mcu_nss), .sck(mcu_sck), .mosi(mcu_mosi),
    .grant(m_grant), .req(m_req), .own(m_own), .own_next(m_own_n),
    .sck_fwd(m_sck), .mosi_fwd(m_mosi)
  );
  assign m_grant = m_req & ~c_own;
`ifdef CORE_LOGIC_COP_EN
  logic c_req, c_grant;
  core_logic_spi_slave_port #(.SYNC_STAGES(SYNC_STAGES)) u_cop (
    .clk(clk), .reset(reset), .nss(cop_nss), .sck(cop_sck), .mosi(cop_mosi),
    .grant(c_grant), .req(c_req), .own(c_own), .own_next(c_own_n),
    .sck_fwd(c_sck), .mosi_fwd(c_mosi)
  );
  // simultaneous requests resolve to the MCU
  assign c_grant = c_req & ~m_own & ~m_req;
`else
  logic cop_unused;
  assign cop_unused = ^{cop_nss, cop_sck, cop_mosi};
  assign {c_own, c_own_n, c_sck, c_mosi} = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_nss <= 1'b1;
      ram_sck <= 1'b0;
      ram_mosi <= 1'b0;
      mcu_miso <= 1'b0;
      cop_miso <= 1'b0;
    end else begin
      ram_nss <= ~(m_own_n | c_own_n);
      ram_sck <= m_own_n ? m_sck : c_own_n & c_sck;
      ram_mosi <= m_own_n ? m_mosi : c_own_n & c_mosi;
      mcu_miso <= m_own & ram_miso;
      cop_miso <= c_own & ram_miso;
    end
  end
endmodule

// File: tb/tb_core_logic.sv
// tb_core_logic: directed self-checking bench for core_logic
module tb_core_logic;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mcu_nss = 1'b1, mcu_sck = 1'b0, mcu_mosi = 1'b0, mcu_miso;
  logic cop_nss = 1'b1, cop_sck = 1'b0, cop_mosi = 1'b0, cop_miso;
  logic ram_nss, ram_sck, ram_mosi, ram_miso;
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int nss_low = 0;
  int p0, n0;
  logic ram_sck_d = 1'b0;
  logic [23:0] cap = '0;
  logic [31:0] mcap = '0;
  logic [31:0] ccap = '0;

  always #5 clk = ~clk;
  assign ram_miso = ~ram_mosi;

  core_logic dut (
    .clk(clk), .reset(reset),
    .mcu_nss(mcu_nss), .mcu_sck(mcu_sck), .mcu_mosi(mcu_mosi), .mcu_miso(mcu_miso),
    .cop_nss(cop_nss), .cop_sck(cop_sck), .cop_mosi(cop_mosi), .cop_miso(cop_miso),
    .ram_nss(ram_nss), .ram_sck(ram_sck), .ram_mosi(ram_mosi), .ram_miso(ram_miso)
  );

  always @(negedge clk) begin
    ram_sck_d <= ram_sck;
    if (ram_sck && !ram_sck_d) begin
      pulses <= pulses + 1;
      cap <= {ram_mosi, cap[23:1]};
    end
    if (!ram_nss) nss_low <= nss_low + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic m, input logic c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (m) mcu_mosi = b[i];
      if (c) cop_mosi = b[i];
      tick(8);
      mcap = {mcu_miso, mcap[31:1]};
      ccap = {cop_miso, ccap[31:1]};
      if (m) mcu_sck = 1'b1;
      if (c) cop_sck = 1'b1;
      tick(8);
      mcu_sck = 1'b0;
      cop_sck = 1'b0;
    end
  endtask

  initial begin
    tick(2);
    chk("rst_ram_nss", 32'(ram_nss), 32'd1);
    chk("rst_ram_sck", 32'(ram_sck), 32'd0);
    chk("rst_ram_mosi", 32'(ram_mosi), 32'd0);
    chk("rst_mcu_miso", 32'(mcu_miso), 32'd0);
    chk("rst_cop_miso", 32'(cop_miso), 32'd0);
    reset = 1'b0;
    tick(8);

    p0 = pulses; n0 = nss_low;
    mcu_nss = 1'b0; tick(8);
    xfer(1'b1, 1'b0, 8'h00);
    tick(8); mcu_nss = 1'b1; tick(8);
    chk("op00_nss_low", 32'(nss_low - n0), 32'd0);
    chk("op00_pulses", 32'(pulses - p0), 32'd0);

    p0 = pulses; n0 = nss_low;
    mcu_nss = 1'b0; tick(8);
    xfer(1'b1, 1'b0, 8'd65);
    xfer(1'b1, 1'b0, 8'h01);
    tick(8); mcu_nss = 1'b1; tick(8);
    chk("dummy_nss_low", 32'(nss_low - n0), 32'd0);
    chk("dummy_pulses", 32'(pulses - p0), 32'd0);
    chk("dummy_miso", 32'(mcap[31:16]), 32'd0);

    p0 = pulses;
    mcu_nss = 1'b0; tick(8);
    chk("acc_nss_pre", 32'(ram_nss), 32'd1);
    xfer(1'b1, 1'b0, 8'h01);
    chk("acc_nss_grant", 32'(ram_nss), 32'd0);
    chk("acc_sck_grant", 32'(ram_sck), 32'd0);
    xfer(1'b1, 1'b0, 8'd41);
    xfer(1'b1, 1'b0, 8'd42);
    xfer(1'b1, 1'b0, 8'd50);
    tick(8);
    chk("acc_pulses", 32'(pulses - p0), 32'd24);
    chk("acc_mosi", 32'(cap), 32'h322A29);
    chk("acc_miso", mcap, 32'hCDD5D600);
    chk("acc_cop_miso", ccap, 32'd0);
    mcu_nss = 1'b1; tick(2);
    chk("acc_nss_lat", 32'(ram_nss), 32'd0);
    tick(1);
    chk("acc_nss_rel", 32'(ram_nss), 32'd1);
    tick(6);
    chk("acc_rel_sck", 32'(ram_sck), 32'd0);
    chk("acc_rel_mosi", 32'(ram_mosi), 32'd0);
    chk("acc_rel_miso", 32'(mcu_miso), 32'd0);

`ifdef CORE_LOGIC_COP_EN
    p0 = pulses;
    mcu_nss = 1'b0; cop_nss = 1'b0; tick(8);
    xfer(1'b1, 1'b1, 8'h01);
    chk("arb_nss", 32'(ram_nss), 32'd0);
    xfer(1'b1, 1'b0, 8'h33);
    tick(8);
    chk("arb_pulses", 32'(pulses - p0), 32'd8);
    chk("arb_mosi", 32'(cap[23:16]), 32'h33);
    chk("arb_mcu_miso", 32'(mcap[31:24]), 32'hCC);
    chk("arb_cop_miso", 32'(ccap[31:24]), 32'h00);
    mcu_nss = 1'b1; cop_nss = 1'b1; tick(8);
    chk("arb_rel", 32'(ram_nss), 32'd1);
    p0 = pulses;
    cop_nss = 1'b0; tick(8);
    xfer(1'b0, 1'b1, 8'h01);
    chk("cop_nss", 32'(ram_nss), 32'd0);
    xfer(1'b0, 1'b1, 8'hC3);
    tick(8);
    chk("cop_pulses", 32'(pulses - p0), 32'd8);
    chk("cop_mosi", 32'(cap[23:16]), 32'hC3);
    chk("cop_miso", 32'(ccap[31:24]), 32'h3C);
    chk("cop_mcu_miso", 32'(mcap[31:24]), 32'h00);
    cop_nss = 1'b1; tick(8);
    chk("cop_rel", 32'(ram_nss), 32'd1);
`else
    p0 = pulses; n0 = nss_low;
    cop_nss = 1'b0; tick(8);
    xfer(1'b0, 1'b1, 8'h01);
    xfer(1'b0, 1'b1, 8'hC3);
    tick(8); cop_nss = 1'b1; tick(8);
    chk("nocop_nss_low", 32'(nss_low - n0), 32'd0);
    chk("nocop_pulses", 32'(pulses - p0), 32'd0);
    chk("nocop_miso", 32'(ccap[31:16]), 32'd0);
`endif

    mcu_nss = 1'b0; tick(8);
    xfer(1'b1, 1'b0, 8'h01);
    xfer(1'b1, 1'b0, 8'd41);
    chk("mid_nss_pre", 32'(ram_nss), 32'd0);
    reset = 1'b1; tick(1);
    chk("mid_nss_rst", 32'(ram_nss), 32'd1);
    chk("mid_sck_rst", 32'(ram_sck), 32'd0);
    reset = 1'b0; tick(8);
    p0 = pulses; n0 = nss_low;
    xfer(1'b1, 1'b0, 8'd42);
    tick(8);
    chk("mid_no_fall_pulses", 32'(pulses - p0), 32'd0);
    chk("mid_no_fall_nss", 32'(nss_low - n0), 32'd0);
    mcu_nss = 1'b1; tick(8);

    p0 = pulses;
    mcu_nss = 1'b0; tick(8);
    xfer(1'b1, 1'b0, 8'h01);
    chk("post_nss", 32'(ram_nss), 32'd0);
    xfer(1'b1, 1'b0, 8'h5A);
    tick(8);
    chk("post_pulses", 32'(pulses - p0), 32'd8);
    chk("post_mosi", 32'(cap[23:16]), 32'h5A);
    chk("post_miso", 32'(mcap[31:24]), 32'hA5);
    mcu_nss = 1'b1; tick(4);
    chk("post_rel", 32'(ram_nss), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
